// File: rtl/hdmi_reset_sequencer_pkg.sv
// Shared definitions for the HDMI reset sequencer: state encoding, the default
// board clock frequency and a small sizing helper.
package hdmi_reset_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK  = 3'd0,
      ST_STABLE     = 3'd1,
      ST_REL_SERDES = 3'd2,
      ST_REL_ENC    = 3'd3,
      ST_RUNNING    = 3'd4,
      ST_FAULT      = 3'd5
   } seq_state_t;

   // 27 MHz board oscillator feeding hdmi_pll
   localparam int DEFAULT_CLK_FREQ = 27_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hdmi_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit. Both flops reset
// to 0 so a "good" status is never reported straight out of reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // First flop may go metastable; second flop gives it a full cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/hdmi_reset_sequencer.sv
// HDMI pipeline bring-up sequencer. Waits for a stable PLL lock, then releases
// serializer, TMDS encoder and timing generator resets in order. Lock loss
// tears everything down and counts a retry; too many retries latch FAULT.
module hdmi_reset_sequencer
   import hdmi_reset_sequencer_pkg::*;
#(
   parameter int CLK_FREQ           = DEFAULT_CLK_FREQ,
   parameter int LOCK_STABLE_CYCLES = 27_000,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int RETRY_LIMIT        = 3,
   localparam int RETRY_W           = $clog2(RETRY_LIMIT + 2)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               restart,
   input  logic               clear_fault,
   output logic               rst_serdes_n,
   output logic               rst_encoder_n,
   output logic               rst_timing_n,
   output logic               video_ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               led
);

   localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES) + 1);
   localparam int LED_W = $clog2(CLK_FREQ);

   // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle,
   // so the window counter starts one short of the full length.
   localparam logic [CNT_W-1:0]   STABLE_LOAD    = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   GAP_LOAD       = CNT_W'(STAGE_GAP_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_ONE        = CNT_W'(1);
   localparam logic [LED_W-1:0]   LED_RUN_TERM   = LED_W'(CLK_FREQ / 2 - 1);
   localparam logic [LED_W-1:0]   LED_FAULT_TERM = LED_W'(CLK_FREQ / 8 - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX      = RETRY_W'(RETRY_LIMIT);
   localparam logic [RETRY_W-1:0] RETRY_SAT      = RETRY_W'(RETRY_LIMIT + 1);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [LED_W-1:0] led_cnt;
   logic             lock_s;
   logic             lock_loss;

   sync_2ff u_lock_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (pll_locked),
      .sync_out (lock_s)
   );

   // Lock only matters once the sequence has started counting or releasing
   assign lock_loss = !lock_s && ((state == ST_STABLE) || (state == ST_REL_SERDES) ||
                                  (state == ST_REL_ENC) || (state == ST_RUNNING));

   // Sequencer FSM with shared stage counter, retry counter and LED blinker
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_WAIT_LOCK;
         cnt           <= '0;
         led_cnt       <= '0;
         led           <= 1'b0;
         rst_serdes_n  <= 1'b0;
         rst_encoder_n <= 1'b0;
         rst_timing_n  <= 1'b0;
         video_ready   <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= '0;
      end else begin
         led_cnt <= '0;
         led     <= 1'b0;
         if (state == ST_FAULT) begin
            if (clear_fault) begin
               state     <= ST_WAIT_LOCK;
               cnt       <= '0;
               fault     <= 1'b0;
               retry_cnt <= '0;
            end else if (led_cnt == LED_FAULT_TERM) begin
               led <= ~led;
            end else begin
               led     <= led;
               led_cnt <= led_cnt + LED_W'(1);
            end
         end else if (lock_loss) begin
            state         <= ST_WAIT_LOCK;
            cnt           <= '0;
            rst_serdes_n  <= 1'b0;
            rst_encoder_n <= 1'b0;
            rst_timing_n  <= 1'b0;
            video_ready   <= 1'b0;
            if (state != ST_STABLE) begin
               if (retry_cnt != RETRY_SAT) begin
                  retry_cnt <= retry_cnt + RETRY_W'(1);
               end
               if (retry_cnt == RETRY_MAX) begin
                  state <= ST_FAULT;
                  fault <= 1'b1;
               end
            end
         end else if (restart) begin
            state         <= ST_WAIT_LOCK;
            cnt           <= '0;
            rst_serdes_n  <= 1'b0;
            rst_encoder_n <= 1'b0;
            rst_timing_n  <= 1'b0;
            video_ready   <= 1'b0;
         end else begin
            case (state)
               ST_WAIT_LOCK: begin
                  cnt <= '0;
                  if (lock_s) begin
                     if (LOCK_STABLE_CYCLES == 1) begin
                        state        <= ST_REL_SERDES;
                        cnt          <= GAP_LOAD;
                        rst_serdes_n <= 1'b1;
                     end else begin
                        state <= ST_STABLE;
                        cnt   <= STABLE_LOAD;
                     end
                  end
               end
               ST_STABLE: begin
                  if (cnt == CNT_ONE) begin
                     state        <= ST_REL_SERDES;
                     cnt          <= GAP_LOAD;
                     rst_serdes_n <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               ST_REL_SERDES: begin
                  if (cnt == CNT_ONE) begin
                     state         <= ST_REL_ENC;
                     cnt           <= GAP_LOAD;
                     rst_encoder_n <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               ST_REL_ENC: begin
                  if (cnt == CNT_ONE) begin
                     state        <= ST_RUNNING;
                     cnt          <= '0;
                     rst_timing_n <= 1'b1;
                     video_ready  <= 1'b1;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               ST_RUNNING: begin
                  if (led_cnt == LED_RUN_TERM) begin
                     led <= ~led;
                  end else begin
                     led     <= led;
                     led_cnt <= led_cnt + LED_W'(1);
                  end
               end
               default: begin
                  state         <= ST_WAIT_LOCK;
                  cnt           <= '0;
                  rst_serdes_n  <= 1'b0;
                  rst_encoder_n <= 1'b0;
                  rst_timing_n  <= 1'b0;
                  video_ready   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hdmi_reset_sequencer.sv
// Directed bench for hdmi_reset_sequencer. Expected output snapshots are queued
// against absolute clock-edge numbers when stimulus is scheduled and compared
// on the falling edge after that rising edge.
module tb_hdmi_reset_sequencer;

   localparam int L  = 8;
   localparam int G  = 4;
   localparam int RL = 2;
   localparam int CF = 32;

   localparam logic [4:0] F_NONE  = 5'b00000;
   localparam logic [4:0] F_SER   = 5'b10000;
   localparam logic [4:0] F_ENC   = 5'b11000;
   localparam logic [4:0] F_RUN   = 5'b11110;
   localparam logic [4:0] F_FAULT = 5'b00001;
   localparam logic [7:0] ALL     = 8'hFF;
   localparam logic [7:0] NOLED   = 8'hFE;

   typedef struct {
      int          cyc;
      logic [95:0] tag;
      logic [7:0]  exp;
      logic [7:0]  mask;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       clear_fault = 1'b0;
   logic       rst_serdes_n, rst_encoder_n, rst_timing_n, video_ready, fault, led;
   logic [1:0] retry_cnt;
   logic [7:0] obs;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t mon_item;

   hdmi_reset_sequencer #(
      .CLK_FREQ           (CF),
      .LOCK_STABLE_CYCLES (L),
      .STAGE_GAP_CYCLES   (G),
      .RETRY_LIMIT        (RL)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .restart       (restart),
      .clear_fault   (clear_fault),
      .rst_serdes_n  (rst_serdes_n),
      .rst_encoder_n (rst_encoder_n),
      .rst_timing_n  (rst_timing_n),
      .video_ready   (video_ready),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .led           (led)
   );

   assign obs = {rst_serdes_n, rst_encoder_n, rst_timing_n, video_ready, fault, retry_cnt, led};

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Rising-edge counter; edge n is the one after which cyc == n
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ov(input logic [4:0] flags, input logic [1:0] r, input logic l);
      return {flags, r, l};
   endfunction

   task automatic check_output(input logic [95:0] tag, input logic [7:0] exp,
                               input logic [7:0] mask, input int at);
      checks++;
      assert ((obs & mask) === (exp & mask)) else begin
         failures++;
         $error("[TB] FAIL %0s edge=%0d observed=%b expected=%b mask=%b", tag, at, obs, exp, mask);
      end
   endtask

   task automatic push(input int at, input logic [95:0] tag, input logic [7:0] exp,
                       input logic [7:0] mask);
      exp_t item;
      int   i = 0;
      item = '{at, tag, exp, mask};
      while (i < sb.size() && sb[i].cyc <= at) i++;
      sb.insert(i, item);
   endtask

   // Returns on the falling edge just before rising edge e, so inputs set now are sampled at e
   task automatic apply_stimulus(input int e);
      if (cyc > e - 1) begin
         $display("[TB] FAIL schedule actual_edge=%0d required_before=%0d", cyc, e);
         $fatal(1, "[TB] stimulus schedule overrun");
      end
      while (cyc < e - 1) @(negedge clk);
   endtask

   // Expected outputs for a clean bring-up where pll_locked was first sampled high at edge k
   task automatic sequence_checks(input int k, input int r, input int last);
      logic [1:0] rr;
      rr = 2'(r);
      push(k + 8, "seq_hold", ov(F_NONE, rr, 1'b0), ALL);
      push(k + 9, "seq_serdes", ov(F_SER, rr, 1'b0), ALL);
      if (last >= 13) begin
         push(k + 12, "seq_gap_enc", ov(F_SER, rr, 1'b0), ALL);
         push(k + 13, "seq_encoder", ov(F_ENC, rr, 1'b0), ALL);
      end
      if (last >= 49) begin
         push(k + 16, "seq_gap_tim", ov(F_ENC, rr, 1'b0), ALL);
         push(k + 17, "seq_running", ov(F_RUN, rr, 1'b0), ALL);
         push(k + 32, "led_pre", ov(F_RUN, rr, 1'b0), ALL);
         push(k + 33, "led_on", ov(F_RUN, rr, 1'b1), ALL);
         push(k + 48, "led_hold", ov(F_RUN, rr, 1'b1), ALL);
         push(k + 49, "led_off", ov(F_RUN, rr, 1'b0), ALL);
      end
   endtask

   // Scoreboard consumer: compare every expectation due at this edge
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_item = sb.pop_front();
         check_output(mon_item.tag, mon_item.exp, mon_item.mask, mon_item.cyc);
      end
   end

   // Directed stimulus sequence
   initial begin
      int k, d, c, r, k2, k3, x, guard;

      @(negedge clk);
      check_output("reset_vals", ov(F_NONE, 2'd0, 1'b0), ALL, cyc);
      @(negedge clk);
      rst_n = 1'b1;

      // Short lock drop that lands exactly when the window would have completed
      $display("[TB] lock glitch during STABLE");
      k = 5;
      push(k + 9, "stable_loss", ov(F_NONE, 2'd0, 1'b0), ALL);
      sequence_checks(k + 8, 0, 49);
      apply_stimulus(k);
      pll_locked = 1'b1;
      apply_stimulus(k + 7);
      pll_locked = 1'b0;
      apply_stimulus(k + 8);
      pll_locked = 1'b1;
      k = k + 8;

      // Two recoverable losses in RUNNING
      $display("[TB] lock losses in RUNNING");
      d = k + 52;
      for (int n = 1; n <= 2; n++) begin
         push(d + 1, "pre_loss", ov(F_RUN, 2'(n - 1), 1'b0), NOLED);
         push(d + 2, "loss_drop", ov(F_NONE, 2'(n), 1'b0), ALL);
         sequence_checks(d + 3, n, 49);
         apply_stimulus(d);
         pll_locked = 1'b0;
         apply_stimulus(d + 3);
         pll_locked = 1'b1;
         d = d + 3 + 52;
      end

      // Third loss exceeds the limit and latches FAULT; relock must be ignored
      $display("[TB] fault entry");
      push(d + 1, "pre_fault", ov(F_RUN, 2'd2, 1'b0), NOLED);
      push(d + 2, "fault_entry", ov(F_FAULT, 2'd3, 1'b0), ALL);
      push(d + 5, "fault_led0", ov(F_FAULT, 2'd3, 1'b0), ALL);
      push(d + 6, "fault_led1", ov(F_FAULT, 2'd3, 1'b1), ALL);
      push(d + 10, "fault_led2", ov(F_FAULT, 2'd3, 1'b0), ALL);
      push(d + 20, "fault_hold", ov(F_FAULT, 2'd3, 1'b0), NOLED);
      apply_stimulus(d);
      pll_locked = 1'b0;
      apply_stimulus(d + 3);
      pll_locked = 1'b1;

      // clear_fault with lock already high restarts a full sequence
      $display("[TB] clear_fault");
      c = d + 25;
      push(c - 1, "pre_clear", ov(F_FAULT, 2'd3, 1'b0), NOLED);
      push(c, "clear_fault", ov(F_NONE, 2'd0, 1'b0), ALL);
      sequence_checks(c - 1, 0, 49);
      apply_stimulus(c);
      clear_fault = 1'b1;
      apply_stimulus(c + 1);
      clear_fault = 1'b0;

      // restart alone in RUNNING keeps the retry count
      $display("[TB] restart in RUNNING");
      r = c + 52;
      k2 = r - 1;
      push(r - 1, "pre_restart", ov(F_RUN, 2'd0, 1'b0), NOLED);
      push(r, "restart_drop", ov(F_NONE, 2'd0, 1'b0), ALL);
      sequence_checks(k2, 0, 13);
      apply_stimulus(r);
      restart = 1'b1;
      apply_stimulus(r + 1);
      restart = 1'b0;

      // restart coinciding with a lock loss in REL_ENC counts as a retry
      $display("[TB] restart with lock loss in REL_ENC");
      k3 = k2 + 14;
      push(k2 + 14, "pre_combo", ov(F_ENC, 2'd0, 1'b0), ALL);
      push(k2 + 15, "combo_loss", ov(F_NONE, 2'd1, 1'b0), ALL);
      sequence_checks(k3, 1, 9);
      push(k3 + 10, "mid_serdes", ov(F_SER, 2'd1, 1'b0), ALL);
      apply_stimulus(k2 + 13);
      pll_locked = 1'b0;
      apply_stimulus(k2 + 14);
      pll_locked = 1'b1;
      apply_stimulus(k2 + 15);
      restart = 1'b1;
      apply_stimulus(k2 + 16);
      restart = 1'b0;

      // Asynchronous reset between clock edges in REL_SERDES
      $display("[TB] async reset mid-sequence");
      apply_stimulus(k3 + 11);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset", ov(F_NONE, 2'd0, 1'b0), ALL, cyc);
      x = k3 + 12;
      apply_stimulus(x + 1);
      sequence_checks(x + 1, 0, 49);
      rst_n = 1'b1;

      guard = 0;
      while (sb.size() > 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain pending=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
